calc_requester: RTL and testbench

- Initiator-side driver for the calculator datapath, which registers operands, runs its control FSM and ALU, and returns `res`/`rem`/`done`.
- Accepts one operation per command via a valid/ready handshake.
- Presents operands and a one-cycle start pulse to the calculator, then waits for completion.
- Captures the results and returns them on a valid/ready response channel. Sits between a host/bus adapter and the calculator top level.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/dff_nbits.sv | 26 ++
 rtl/req_timeout_cnt.sv | 33 +++
 rtl/calc_requester.sv | 154 +++++++++++++++
 tb/tb_calc_requester.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_pkg                                                             |
// | Shared types and constants for the calculator requester.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package calc_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] FCT_ADD = 2'b00;
  localparam logic [1:0] FCT_SUB = 2'b01;
  localparam logic [1:0] FCT_MUL = 2'b10;
  localparam logic [1:0] FCT_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } req_state_t;

endpackage
`default_nettype wire

// File: rtl/dff_nbits.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dff_nbits                                                            |
// | N-bit enabled register with asynchronous active-high clear.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dff_nbits #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/req_timeout_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | req_timeout_cnt                                                      |
// | Load/enable down-counter; o_expired is high while the count is zero. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module req_timeout_cnt #(
  parameter int LOAD_VALUE = 63,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(LOAD_VALUE);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/calc_requester.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_requester                                                       |
// | Command/response front end that starts the calculator and captures   |
// | its result. Optional WAIT timeout: define CALC_REQ_TIMEOUT_EN.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module calc_requester
  import calc_pkg::*;
#(
  parameter int width          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [width-1:0]     cmd_a_i,
  input  logic [width-1:0]     cmd_b_i,
  input  logic [1:0]           cmd_fct_i,
  output logic                 calc_start_o,
  output logic [width-1:0]     calc_a_o,
  output logic [width-1:0]     calc_b_o,
  output logic [1:0]           calc_fct_o,
  input  logic [2*width-1:0]   calc_res_i,
  input  logic [2*width-1:0]   calc_rem_i,
  input  logic                 calc_done_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [2*width-1:0]   rsp_res_o,
  output logic [2*width-1:0]   rsp_rem_o,
  output logic [1:0]           rsp_fct_o,
  output logic                 rsp_err_o,
  output logic                 busy_o
);

  req_state_t r_state;
  logic       r_start;
  logic       r_armed;
  logic       r_rsp_valid;
  logic       r_rsp_err;
  logic [1:0] r_rsp_fct;

  logic                   w_accept;
  logic                   w_div0;
  logic                   w_complete;
  logic                   w_expired;
  logic                   w_abort;
  logic                   w_rsp_load;
  logic [2*width+1:0]     w_op_q;
  logic [4*width-1:0]     w_rsp_d;
  logic [4*width-1:0]     w_rsp_q;

  assign w_accept   = (r_state == ST_IDLE) && cmd_valid_i;
  assign w_div0     = (cmd_fct_i == FCT_DIV) && (cmd_b_i == '0);
  // armed guarantees a done level left over from the previous op is ignored
  assign w_complete = (r_state == ST_WAIT) && r_armed && calc_done_i;
  assign w_abort    = (r_state == ST_WAIT) && !w_complete && w_expired;
  assign w_rsp_load = w_complete || w_abort || (w_accept && w_div0);
  assign w_rsp_d    = w_complete ? {calc_res_i, calc_rem_i} : '0;

  dff_nbits #(.N(2*width+2)) u_op_reg (
    .clk  (clock_i),
    .rst  (reset_i),
    .i_en (w_accept),
    .i_d  ({cmd_fct_i, cmd_a_i, cmd_b_i}),
    .o_q  (w_op_q)
  );

  dff_nbits #(.N(4*width)) u_rsp_reg (
    .clk  (clock_i),
    .rst  (reset_i),
    .i_en (w_rsp_load),
    .i_d  (w_rsp_d),
    .o_q  (w_rsp_q)
  );

`ifdef CALC_REQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Loaded with N-1 in START so it reads zero during the N-th WAIT cycle
  req_timeout_cnt #(.LOAD_VALUE(TIMEOUT_CYCLES - 1), .CNT_W(TMO_W)) u_timeout (
    .clk       (clock_i),
    .rst       (reset_i),
    .i_load    (r_state == ST_START),
    .i_en      (r_state == ST_WAIT),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_start     <= 1'b0;
      r_armed     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_fct   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            if (w_div0) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_fct   <= cmd_fct_i;
            end else begin
              r_state <= ST_START;
              r_start <= 1'b1;
            end
          end
        end
        ST_START: begin
          r_start <= 1'b0;
          r_armed <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!calc_done_i) begin
            r_armed <= 1'b1;
          end
          if (w_complete || w_abort) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_abort;
            r_rsp_fct   <= calc_fct_o;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign {calc_fct_o, calc_a_o, calc_b_o} = w_op_q;
  assign {rsp_res_o, rsp_rem_o}           = w_rsp_q;

  assign cmd_ready_o  = (r_state == ST_IDLE);
  assign busy_o       = (r_state != ST_IDLE);
  assign calc_start_o = r_start;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_err_o    = r_rsp_err;
  assign rsp_fct_o    = r_rsp_fct;

endmodule
`default_nettype wire

// File: tb/tb_calc_requester.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_calc_requester                                                    |
// | Scoreboard bench for calc_requester with a behavioural calculator.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_calc_requester;
  import calc_pkg::*;

  localparam int W  = 8;
  localparam int RW = 2 * W;
  localparam logic [56:0] RST_OUTS = {1'b1, 56'b0};

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [W-1:0]  cmd_a_i, cmd_b_i;
  logic [1:0]    cmd_fct_i;
  logic          calc_start_o;
  logic [W-1:0]  calc_a_o, calc_b_o;
  logic [1:0]    calc_fct_o;
  logic [RW-1:0] calc_res_i, calc_rem_i;
  logic          calc_done_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [RW-1:0] rsp_res_o, rsp_rem_o;
  logic [1:0]    rsp_fct_o;
  logic          rsp_err_o;
  logic          busy_o;

  calc_requester #(.width(W), .TIMEOUT_CYCLES(64)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_fct_i(cmd_fct_i),
    .calc_start_o(calc_start_o), .calc_a_o(calc_a_o), .calc_b_o(calc_b_o),
    .calc_fct_o(calc_fct_o), .calc_res_i(calc_res_i), .calc_rem_i(calc_rem_i),
    .calc_done_i(calc_done_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_rem_o(rsp_rem_o), .rsp_fct_o(rsp_fct_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [RW-1:0] res;
    logic [RW-1:0] rem;
    logic [1:0]    fct;
    logic          err;
  } rsp_t;

  typedef struct {
    rsp_t r;
    int   lat;   // exact latency, 0 = at least 3 cycles
    int   acc;
    int   bp;
  } exp_t;

  typedef struct {
    int s;
    int l;
    bit h;
  } cfg_t;

  exp_t exp_q[$];
  cfg_t cfg_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_push  = 0;
  int   n_hs    = 0;
  int   n_starts = 0;
  int   n_exp_starts = 0;

  always @(posedge clock_i) cyc <= cyc + 1;
  always @(posedge clock_i) if (!reset_i && rsp_valid_o && rsp_ready_i) n_hs <= n_hs + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rsp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f);
    rsp_t r;
    r = '0;
    r.fct = f;
    case (f)
      FCT_ADD: r.res = RW'(a) + RW'(b);
      FCT_SUB: r.res = RW'(a) - RW'(b);
      FCT_MUL: r.res = RW'(a) * RW'(b);
      default: begin
        if (b == 0) r.err = 1'b1;
        else begin
          r.res = RW'(a / b);
          r.rem = RW'(a % b);
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [56:0] outs();
    return {cmd_ready_o, calc_start_o, calc_a_o, calc_b_o, calc_fct_o, rsp_valid_o,
            rsp_res_o, rsp_rem_o, rsp_fct_o, rsp_err_o, busy_o};
  endfunction

  // s: negedges done keeps its old level after start; l: low negedges; h: never complete
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f,
                      input int s, input int l, input bit h, input bit tmo, input int bp);
    exp_t e;
    cfg_t c;
    int   t;
    @(negedge clock_i);
    cmd_valid_i = 1'b1;
    cmd_a_i = a;
    cmd_b_i = b;
    cmd_fct_i = f;
    t = 0;
    while (!cmd_ready_o && t < 300) begin
      @(negedge clock_i);
      t++;
    end
    if (!cmd_ready_o) begin
      check("cmd_accept_bound", 64'd0, 64'd1);
      cmd_valid_i = 1'b0;
      return;
    end
    check("accept_after_rsp_handshake", 64'(n_push - n_hs), 64'd0);
    e.r   = ref_op(a, b, f);
    e.acc = cyc;
    e.bp  = bp;
    e.lat = 0;
    if (tmo) begin
      e.r.res = '0;
      e.r.rem = '0;
      e.r.err = 1'b1;
      e.lat   = 66;
    end
    if (f == FCT_DIV && b == 0) begin
      e.lat = 1;
    end else begin
      c.s = s;
      c.l = l;
      c.h = h;
      cfg_q.push_back(c);
      n_exp_starts++;
    end
    exp_q.push_back(e);
    n_push++;
    @(posedge clock_i);
    #1;
    check("operands_held", 64'({calc_fct_o, calc_a_o, calc_b_o}), 64'({f, a, b}));
    cmd_valid_i = 1'b0;
  endtask

  // Behavioural calculator: garbage results while not done, done level held afterwards
  initial begin
    cfg_t c;
    rsp_t r;
    calc_done_i = 1'b0;
    calc_res_i  = '0;
    calc_rem_i  = '0;
    forever begin
      @(negedge clock_i);
      if (calc_start_o && !reset_i) begin
        if (cfg_q.size() == 0) begin
          check("unexpected_start", 64'd1, 64'd0);
          c.s = 0; c.l = 2; c.h = 0;
        end else begin
          c = cfg_q.pop_front();
        end
        r = ref_op(calc_a_o, calc_b_o, calc_fct_o);
        calc_res_i = RW'($urandom);
        calc_rem_i = RW'($urandom);
        repeat (c.s) @(negedge clock_i);
        calc_done_i = 1'b0;
        if (!c.h) begin
          repeat (c.l) @(negedge clock_i);
          calc_done_i = 1'b1;
          calc_res_i  = r.res;
          calc_rem_i  = r.rem;
        end
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    rsp_t cur, snap;
    exp_t e;
    int   hold;
    bit   in_rsp, prev_start;
    rsp_ready_i = 1'b0;
    hold = 0;
    in_rsp = 0;
    prev_start = 0;
    forever begin
      @(negedge clock_i);
      if (reset_i) begin
        in_rsp = 0;
        prev_start = 0;
        rsp_ready_i = 1'b0;
        continue;
      end
      if (calc_start_o) begin
        n_starts++;
        check("start_single_cycle", 64'(prev_start), 64'd0);
      end
      prev_start = calc_start_o;
      if (rsp_valid_o) begin
        check("cmd_ready_low_in_resp", 64'(cmd_ready_o), 64'd0);
        cur = {rsp_res_o, rsp_rem_o, rsp_fct_o, rsp_err_o};
        if (!in_rsp) begin
          in_rsp = 1;
          snap = cur;
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
            hold = 0;
          end else begin
            e = exp_q.pop_front();
            hold = e.bp;
            check("rsp_fields", 64'(cur), 64'(e.r));
            if (e.lat != 0) check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
            else            check("rsp_min_latency", 64'((cyc - e.acc) >= 3), 64'd1);
          end
        end else begin
          check("rsp_stable", 64'(cur), 64'(snap));
        end
        if (hold > 0) begin
          rsp_ready_i = 1'b0;
          hold--;
        end else begin
          rsp_ready_i = ($urandom_range(0, 2) != 0);
        end
        if (rsp_ready_i) in_rsp = 0;
      end else begin
        rsp_ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failed so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic [1:0]   f;
    int           s, t;
    reset_i = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_a_i = '0;
    cmd_b_i = '0;
    cmd_fct_i = '0;
    repeat (2) @(negedge clock_i);
    check("reset_state", 64'(outs()), 64'(RST_OUTS));
    reset_i = 1'b0;

    send(8'd25, 8'd17, FCT_ADD, 0, 3, 0, 0, 0);
    send(8'd200, 8'd3, FCT_MUL, 1, 2, 0, 0, 5);
    send(8'd10, 8'd20, FCT_SUB, 0, 2, 0, 0, 0);
    send(8'd9, 8'd0, FCT_DIV, 0, 0, 0, 0, 0);
    send(8'd23, 8'd3, FCT_DIV, 2, 1, 0, 0, 0);

    // Reset while the requester sits in WAIT
    send(8'd77, 8'd11, FCT_ADD, 0, 1, 1, 0, 0);
    repeat (4) @(negedge clock_i);
    #2 reset_i = 1'b1;
    #1 check("async_reset_mid_op", 64'(outs()), 64'(RST_OUTS));
    exp_q.delete();
    n_push--;
    @(negedge clock_i);
    reset_i = 1'b0;
    send(8'd10, 8'd4, FCT_SUB, 0, 2, 0, 0, 0);

`ifdef CALC_REQ_TIMEOUT_EN
    send(8'd5, 8'd6, FCT_MUL, 0, 0, 1, 1, 0);
    send(8'd5, 8'd6, FCT_MUL, 0, 64, 0, 0, 0);
`endif

    for (int i = 0; i < 200; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      f = 2'($urandom_range(0, 3));
      s = $urandom_range(0, 2);
      send(a, b, f, s, (s == 0) ? $urandom_range(2, 5) : $urandom_range(1, 4), 0, 0,
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      repeat ($urandom_range(0, 2)) @(negedge clock_i);
    end

    t = 0;
    while ((exp_q.size() != 0 || n_push != n_hs) && t < 2000) begin
      @(negedge clock_i);
      t++;
    end
    check("drain_responses", 64'(exp_q.size() + (n_push - n_hs)), 64'd0);
    check("start_count", 64'(n_starts), 64'(n_exp_starts));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
